bcd_to_binary_seq: RTL and testbench

Sequential 4-digit packed-BCD to binary converter using reverse double dabble: one shift-and-correct iteration per clock, with a start/busy/done handshake. It sits in the frequency-counter datapath wherever decimal user entry, such as gate-time or threshold settings from switches or keypad, must be turned into a binary count. It is the inverse of the existing binary-to-BCD display path. An input-validity check flags any non-decimal digit.

---
 rtl/bcd_to_binary_seq.sv | 160 ++++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
//
// Converts a 4-digit packed-BCD value (0..9999) into a 14-bit binary count
// using reverse double dabble: the 30-bit working register {bcd, 14'b0} is
// shifted right once per clock. After each shift, every BCD digit nibble that
// reads 8 or more has 3 subtracted from it. After 14 iterations the low 14
// bits hold the binary result. A request containing a non-decimal digit is
// rejected in one cycle with err raised and a zero result.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   start    in   1   conversion request, accepted only while idle
//   bcd_in   in  16   packed BCD {thousands, hundreds, tens, ones}
//   bin_out  out 14   registered binary result, held until the next completion
//   busy     out  1   conversion in progress
//   done     out  1   one-cycle completion pulse per accepted request
//   err      out  1   last accepted request had a digit > 9
// -----------------------------------------------------------------------------
module bcd_to_binary_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bcd_in,
    output logic [13:0] bin_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Index of the final iteration (14 iterations, counted 0..13).
    localparam logic [3:0] LAST_ITER = 4'd13;

    state_t      state_r, state_s;
    logic [29:0] work_r,  work_s;
    logic [3:0]  cnt_r,   cnt_s;
    logic [13:0] bin_r,   bin_s;
    logic        busy_r,  busy_s;
    logic        done_r,  done_s;
    logic        err_r,   err_s;
    logic [29:0] step_s;

    // True when every nibble of the packed BCD word is a decimal digit.
    function automatic logic bcd_valid(input logic [15:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // One reverse double-dabble iteration: logical shift right, then each
    // digit nibble (bits 29..14) that reads >= 8 is reduced by 3. A digit
    // nibble that took a shifted-in 1 from the digit above reads 8 + x/2,
    // and subtracting 3 leaves it at 5 + x/2, which is the value that nibble
    // must hold for the next shift to halve the decimal weight correctly.
    // Nibbles are corrected independently, with no borrow between them.
    function automatic logic [29:0] dabble_step(input logic [29:0] w);
        logic [29:0] sh;
        sh = {1'b0, w[29:1]};
        for (int i = 0; i < 4; i++) begin
            if (sh[14 + 4*i +: 4] >= 4'd8) begin
                sh[14 + 4*i +: 4] = sh[14 + 4*i +: 4] - 4'd3;
            end else begin
                sh[14 + 4*i +: 4] = sh[14 + 4*i +: 4];
            end
        end
        return sh;
    endfunction

    // Result of the current iteration, shared by the working register and
    // the final result capture.
    assign step_s = dabble_step(work_r);

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        cnt_s   = cnt_r;
        bin_s   = bin_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (bcd_valid(bcd_in)) begin
                        err_s   = 1'b0;
                        work_s  = {bcd_in, 14'd0};
                        cnt_s   = 4'd0;
                        busy_s  = 1'b1;
                        state_s = ST_SHIFT;
                    end else begin
                        bin_s  = 14'd0;
                        err_s  = 1'b1;
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start is deliberately ignored here: no queueing, no resample.
                work_s = step_s;
                cnt_s  = cnt_r + 4'd1;
                if (cnt_r == LAST_ITER) begin
                    bin_s   = step_s[13:0];
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            work_r  <= 30'd0;
            cnt_r   <= 4'd0;
            bin_r   <= 14'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            work_r  <= work_s;
            cnt_r   <= cnt_s;
            bin_r   <= bin_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign bin_out = bin_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_seq
//
// Self-checking bench for bcd_to_binary_seq. The reference model computes the
// expected result arithmetically from the decimal digits
// (1000*d3 + 100*d2 + 10*d1 + d0) and flags any digit > 9. Inputs are driven
// and outputs sampled on the falling edge of the clock.
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    bcd_to_binary_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal value of the packed digits.
    function automatic int ref_value(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    // Reference model: all four digits are decimal.
    function automatic bit ref_valid(input logic [15:0] b);
        return (b[15:12] <= 4'd9) && (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Valid request. Caller is at a falling edge; returns at the falling edge
    // of the done cycle. inject_at > 0 pulses a second start while busy.
    task automatic run_valid(input logic [15:0] bcd, input int inject_at);
        int exp;
        exp    = ref_value(bcd);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("done_after_accept", {31'd0, done}, 32'd0);
        check("err_cleared", {31'd0, err}, 32'd0);
        for (int i = 1; i <= 13; i++) begin
            if (i == inject_at) begin
                start  = 1'b1;
                bcd_in = 16'h5678;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("busy_during_shift", {31'd0, busy}, 32'd1);
            check("no_early_done", {31'd0, done}, 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_at_14", {31'd0, done}, 32'd1);
        check("busy_low_at_14", {31'd0, busy}, 32'd0);
        check("bin_out", {18'd0, bin_out}, 32'(exp));
        check("err_valid", {31'd0, err}, 32'd0);
    endtask

    // Invalid request: one-cycle rejection.
    task automatic run_invalid(input logic [15:0] bcd);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start = 1'b0;
        check("inv_done", {31'd0, done}, 32'd1);
        check("inv_err", {31'd0, err}, 32'd1);
        check("inv_bin", {18'd0, bin_out}, 32'd0);
        check("inv_busy", {31'd0, busy}, 32'd0);
    endtask

    // One idle cycle: done must have dropped, busy low.
    task automatic idle_check(input logic exp_err, input int exp_bin);
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_err_held", {31'd0, err}, {31'd0, exp_err});
        check("idle_bin_held", {18'd0, bin_out}, 32'(exp_bin));
    endtask

    initial begin
        logic [15:0] r;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 16'd0;
        @(negedge clk);
        check("rst_bin", {18'd0, bin_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero, full-scale, and 0x4095 followed by back-to-back 0x0001.
        run_valid(16'h0000, 0);
        idle_check(1'b0, 0);
        run_valid(16'h9999, 0);
        check("max_value", {18'd0, bin_out}, 32'h270F);
        idle_check(1'b0, 9999);
        run_valid(16'h4095, 0);
        check("val_4095", {18'd0, bin_out}, 32'h0FFF);
        run_valid(16'h0001, 0);
        idle_check(1'b0, 1);

        // Invalid digit, then a valid request clears err.
        run_invalid(16'h12A4);
        idle_check(1'b1, 0);
        run_valid(16'h0042, 0);
        check("val_0042", {18'd0, bin_out}, 32'h002A);
        idle_check(1'b0, 42);

        // Start while busy is ignored; single done.
        run_valid(16'h1234, 5);
        check("val_1234", {18'd0, bin_out}, 32'h04D2);
        idle_check(1'b0, 1234);
        idle_check(1'b0, 1234);

        // Reset during iteration 7.
        start  = 1'b1;
        bcd_in = 16'h8888;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 6; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_bin", {18'd0, bin_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_no_done", {31'd0, done}, 32'd0);
        end
        run_valid(16'h0010, 0);
        check("val_0010", {18'd0, bin_out}, 32'h000A);
        idle_check(1'b0, 10);

        // Randomised requests against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 7) == 0) r[4*d +: 4] = 4'($urandom_range(10, 15));
                else                            r[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if (ref_valid(r)) begin
                run_valid(r, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0);
                idle_check(1'b0, ref_value(r));
            end else begin
                run_invalid(r);
                idle_check(1'b1, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
